shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shift_step.sv | 35 +++
 rtl/shift_seq_ctrl.sv | 95 +++++++++
 tb/tb_shift_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift/rotate sequencer: FSM encoding and step opcodes.
package shift_seq_pkg;

    localparam int unsigned STEP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Opcode is {s3, s2}: s3 selects rotate, s2 selects right.
    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

endpackage

// File: rtl/shift_step.sv
// One 1-bit shift or rotate step on an 8-bit word, also reporting the bit that leaves it.
module shift_step
    import shift_seq_pkg::*;
(
    input  logic [STEP_W-1:0] r,
    input  logic              s3,
    input  logic              s2,
    output logic [STEP_W-1:0] next,
    output logic              bit_out
);

    always_comb begin
        next    = r;
        bit_out = 1'b0;
        case ({s3, s2})
            OP_LSL: begin
                next    = {r[STEP_W-2:0], 1'b0};
                bit_out = r[STEP_W-1];
            end
            OP_LSR: begin
                next    = {1'b0, r[STEP_W-1:1]};
                bit_out = r[0];
            end
            OP_ROL: begin
                next    = {r[STEP_W-2:0], r[STEP_W-1]};
                bit_out = r[STEP_W-1];
            end
            default: begin
                next    = {r[0], r[STEP_W-1:1]};
                bit_out = r[0];
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: applies count 1-bit steps to A, one per clock,
// then pulses done with the result and the last exiting bit.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic              s3,
    input  logic              s2,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                s3_q, s3_d;
    logic                s2_q, s2_d;
    logic [DATA_W-1:0]   step_next;
    logic                step_bit;

    shift_step u_step (
        .r       (result_q),
        .s3      (s3_q),
        .s2      (s2_q),
        .next    (step_next),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            carry_q     <= 1'b0;
            remaining_q <= '0;
            s3_q        <= 1'b0;
            s2_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            remaining_q <= remaining_d;
            s3_q        <= s3_d;
            s2_q        <= s2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        remaining_d = remaining_q;
        s3_d        = s3_q;
        s2_d        = s2_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    result_d    = A;
                    remaining_d = count;
                    s3_d        = s3;
                    s2_d        = s2;
                    carry_d     = 1'b0;
                    state_d     = (count != '0) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                result_d    = step_next;
                carry_d     = step_bit;
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags decode straight from the state register, so they stay glitch-free.
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed scenarios plus random traffic checked every cycle
// against a step-count model of the shift/rotate arithmetic.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic       s3;
    logic       s2;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    shift_seq_ctrl #(.DATA_W(8), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .s3        (s3),
        .s2        (s2),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of A after k steps of op, computed in one shot.
    function automatic logic [7:0] f_res(input logic [7:0] a, input logic [1:0] op, input int k);
        logic [7:0] r;
        case (op)
            2'b00:   r = a << k;
            2'b01:   r = a >> k;
            2'b10:   r = (a << k) | (a >> (8 - k));
            default: r = (a >> k) | (a << (8 - k));
        endcase
        return r;
    endfunction

    // Last bit to leave after k steps: original bit 8-k going left, bit k-1 going right.
    function automatic logic f_car(input logic [7:0] a, input logic [1:0] op, input int k);
        if (k == 0) return 1'b0;
        return op[0] ? a[k-1] : a[8-k];
    endfunction

    // Reference model: phase 0 idle, 1 busy, 2 done.
    int         m_phase = 0;
    int         m_k = 0;
    int         m_n = 0;
    logic [7:0] m_a = '0;
    logic [1:0] m_op = '0;
    logic [7:0] m_res = '0;
    logic       m_car = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_res   = '0;
            m_car   = 1'b0;
        end else if (m_phase == 1) begin
            m_k++;
            m_res = f_res(m_a, m_op, m_k);
            m_car = f_car(m_a, m_op, m_k);
            if (m_k == m_n) m_phase = 2;
        end else if (start) begin
            m_a     = A;
            m_op    = {s3, s2};
            m_n     = int'(count);
            m_k     = 0;
            m_res   = A;
            m_car   = 1'b0;
            m_phase = (count == 3'd0) ? 2 : 1;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(busy),      32'(m_phase == 1));
            chk("done",      32'(done),      32'(m_phase == 2));
            chk("result",    32'(result),    32'(m_res));
            chk("carry_out", 32'(carry_out), 32'(m_car));
        end
    end

    // Caller sits just after a clock edge; start is held for exactly one edge.
    task automatic start_op(input logic [7:0] a, input logic [1:0] op, input logic [2:0] n);
        start = 1'b1;
        A     = a;
        {s3, s2} = op;
        count = n;
        @(posedge clk); #1;
        start = 1'b0;
        A     = 8'($urandom);
        {s3, s2} = 2'($urandom);
        count = 3'($urandom);
    endtask

    // Waits (bounded) for done; optionally pokes start with junk while busy.
    task automatic wait_done(input bit poke, output int busy_cnt, output bit seen);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (poke && busy) begin
                start = 1'b1;
                A     = 8'($urandom);
                {s3, s2} = 2'($urandom);
                count = 3'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic directed(input string name, input logic [7:0] a, input logic [1:0] op,
                            input logic [2:0] n, input logic [7:0] exp_r, input logic exp_c,
                            input bit poke);
        int bc;
        bit seen;
        start_op(a, op, n);
        wait_done(poke, bc, seen);
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_cycles"}, 32'(bc), 32'(n));
        chk({name, "_result"}, 32'(result), 32'(exp_r));
        chk({name, "_carry"}, 32'(carry_out), 32'(exp_c));
    endtask

    initial begin
        int  bc;
        bit  seen;
        int  done_cnt;
        rst = 1'b1; start = 1'b0; A = '0; s3 = 1'b0; s2 = 1'b0; count = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        directed("lsl3",  8'h96, 2'b00, 3'd3, 8'hB0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("hold_result", 32'(result), 32'h00B0);
        directed("ror3",  8'h96, 2'b11, 3'd3, 8'hD2, 1'b1, 1'b0);
        directed("lsr7",  8'hFF, 2'b01, 3'd7, 8'h01, 1'b1, 1'b0);
        directed("rol7",  8'h01, 2'b10, 3'd7, 8'h80, 1'b0, 1'b0);
        directed("cnt0",  8'h5A, 2'b10, 3'd0, 8'h5A, 1'b0, 1'b0);
        directed("ignore", 8'h96, 2'b00, 3'd3, 8'hB0, 1'b0, 1'b1);
        // Back-to-back: previous call left us in the done cycle.
        directed("b2b",   8'hC3, 2'b10, 3'd2, 8'h0F, 1'b1, 1'b0);
        @(posedge clk); #1;

        start_op(8'hA5, 2'b00, 3'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy",   32'(busy),      32'd0);
        chk("abort_result", 32'(result),    32'd0);
        chk("abort_carry",  32'(carry_out), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 2) == 0);
            A     = 8'($urandom);
            {s3, s2} = 2'($urandom);
            count = 3'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0;
        wait_done(1'b0, bc, seen);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
